// File: rtl/ps2_pkg.sv
// Shared PS/2 scancode types and constants.
// Used by the scancode FIFO controller (optional PS2_TYPEMATIC_FILTER_EN).
package ps2_pkg;

    localparam int PS2_CODE_W  = 10;
    localparam int PS2_EXT_BIT = 9;
    localparam int PS2_BRK_BIT = 8;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] key;
    } ps2_code_t;

    function automatic logic [8:0] ps2_make_id(input ps2_code_t c);
        return {c.ext, c.key};
    endfunction

endpackage

// File: rtl/ps2_scan_fifo_ctrl_if.sv
// Receiver/CPU-side bundle of the PS/2 scancode FIFO controller.
// The master drives codes and strobes; the slave reports FIFO status.
interface ps2_scan_fifo_ctrl_if #(
    parameter int AW     = 3,
    parameter int CODE_W = 10
);
    logic              code_valid;
    logic [CODE_W-1:0] code_in;
    logic              rd;
    logic              clr_ovf;
    logic              ready;
    logic [31:0]       scancode;
    logic [AW:0]       count;
    logic              ovf;

    modport master (
        output code_valid, code_in, rd, clr_ovf,
        input  ready, scancode, count, ovf
    );

    modport slave (
        input  code_valid, code_in, rd, clr_ovf,
        output ready, scancode, count, ovf
    );
endinterface

// File: rtl/ps2_sync_fifo.sv
// Single-clock FIFO: storage, pointers, fill count, full/empty.
// Caller guarantees push is never asserted while full without a pop.
module ps2_sync_fifo #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int CODE_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [CODE_W-1:0] din,
    output logic [CODE_W-1:0] dout,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    logic [CODE_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage needs no reset; empty gates the head downstream.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ps2_scan_fifo_ctrl.sv
// PS/2 scancode FIFO with rd edge-detect pop, sticky overflow and status word.
// Define PS2_TYPEMATIC_FILTER_EN to drop repeated make codes.
import ps2_pkg::*;

module ps2_scan_fifo_ctrl #(
    parameter int DEPTH  = 8,
    parameter int AW     = 3,
    parameter int CODE_W = PS2_CODE_W
) (
    input logic                 clk,
    input logic                 rst,
    ps2_scan_fifo_ctrl_if.slave bus
);

    logic              rd_q;
    logic              ovf_q;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push;
    logic              cand;
    logic              drop;
    logic [CODE_W-1:0] head;
    logic [AW:0]       cnt;

`ifdef PS2_TYPEMATIC_FILTER_EN
    ps2_code_t  code;
    logic       last_vld;
    logic [8:0] last_make;

    assign code = bus.code_in[PS2_CODE_W-1:0];
    assign drop = !code.brk && last_vld
               && (last_make == ps2_make_id(code));

    // A break ends the typematic run so the next make is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_vld  <= 1'b0;
            last_make <= '0;
        end else if (bus.code_valid) begin
            if (code.brk) begin
                last_vld <= 1'b0;
            end else if (!drop) begin
                last_make <= ps2_make_id(code);
                last_vld  <= 1'b1;
            end
        end
    end
`else
    assign drop = 1'b0;
`endif

    assign cand = bus.code_valid && !drop;
    assign pop  = bus.rd && !rd_q && !empty;
    assign push = cand && (!full || pop);

    ps2_sync_fifo #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .CODE_W (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.code_in),
        .dout  (head),
        .count (cnt),
        .full  (full),
        .empty (empty)
    );

    // A new overflow outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            rd_q <= bus.rd;
            if (cand && full && !pop)
                ovf_q <= 1'b1;
            else if (bus.clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    assign bus.ready    = !empty;
    assign bus.count    = cnt;
    assign bus.ovf      = ovf_q;
    assign bus.scancode = {ovf_q, 20'b0, !empty,
                           empty ? {CODE_W{1'b0}} : head};

endmodule
